lc3_int_ctrl: RTL and testbench

Parametrised interrupt controller for the LC-3 core, the multi-source successor to the datapath's single-priority INT/Vector logic. It edge-latches up to NUM_SRC device requests and masks them. It arbitrates by priority and compares the winner against the current PSR priority. On the control FSM's acknowledge it hands the winning vector and priority to the datapath (INTV, Int_Priority) and tracks nesting depth until RTI.

---
 rtl/lc3_int_ctrl.sv | 123 ++++++++++++
 tb/tb_lc3_int_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_int_ctrl.sv
// ============================================================================
// lc3_int_ctrl : multi-source edge-latched interrupt controller for the LC-3
//                (priority arbitration, PSR compare, vector hand-off, nesting)
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_int_ctrl #(
  parameter int NUM_SRC  = 8,
  parameter int PRI_W    = 3,
  parameter int VEC_W    = 8,
  parameter int MAX_NEST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       irq_req,
  input  logic [NUM_SRC-1:0]       irq_mask,
  input  logic [NUM_SRC*PRI_W-1:0] src_pri,
  input  logic [NUM_SRC*VEC_W-1:0] src_vec,
  input  logic [PRI_W-1:0]         cur_priority,
  input  logic                     int_ack,
  input  logic                     int_done,
  output logic                     INT,
  output logic [VEC_W-1:0]         INTV,
  output logic [PRI_W-1:0]         Int_Priority,
  output logic [NUM_SRC-1:0]       ack_src,
  output logic [NUM_SRC-1:0]       pending,
  output logic [3:0]               depth,
  output logic                     err
);

  localparam logic [3:0] MAX_DEPTH = 4'(MAX_NEST);

  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] win_onehot;
  logic [NUM_SRC-1:0] ack_clr;
  logic               win_valid;
  logic [PRI_W-1:0]   win_pri;
  logic [VEC_W-1:0]   win_vec;
  logic               ack_fire;
  logic               int_next;
  logic [3:0]         depth_next;
  logic               err_set;

  assign rise     = irq_req & ~irq_q;
  assign eligible = pending & ~irq_mask;
  assign ack_fire = int_ack & INT;

  // Ascending scan with a strict '>' keeps the lowest index on priority ties.
  always_comb begin
    win_valid  = 1'b0;
    win_pri    = '0;
    win_vec    = '0;
    win_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!win_valid || (src_pri[i*PRI_W +: PRI_W] > win_pri))) begin
        win_valid     = 1'b1;
        win_pri       = src_pri[i*PRI_W +: PRI_W];
        win_vec       = src_vec[i*VEC_W +: VEC_W];
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign ack_clr = (ack_fire && win_valid) ? win_onehot : '0;

  // INT is forced low for the cycle after an ack so the FSM can raise PSR first.
  always_comb begin
    int_next = 1'b0;
    if (!ack_fire) begin
      int_next = win_valid && (win_pri > cur_priority) && (depth < MAX_DEPTH);
    end
  end

  always_comb begin
    depth_next = depth;
    err_set    = 1'b0;
    if (int_ack && !INT) begin
      err_set = 1'b1;
    end
    if (ack_fire && !int_done) begin
      depth_next = depth + 4'd1;
    end else if (!ack_fire && int_done) begin
      if (depth != 4'd0) begin
        depth_next = depth - 4'd1;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q        <= '0;
      pending      <= '0;
      ack_src      <= '0;
      INT          <= 1'b0;
      INTV         <= '0;
      Int_Priority <= '0;
      depth        <= 4'd0;
      err          <= 1'b0;
    end else begin
      irq_q   <= irq_req;
      pending <= (pending & ~ack_clr) | rise;
      ack_src <= ack_clr;
      INT     <= int_next;
      depth   <= depth_next;
      if (err_set) begin
        err <= 1'b1;
      end
      if (ack_fire && win_valid) begin
        INTV         <= win_vec;
        Int_Priority <= win_pri;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lc3_int_ctrl.sv
// ============================================================================
// tb_lc3_int_ctrl : directed self-checking bench for lc3_int_ctrl
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_int_ctrl;

  localparam int NUM_SRC = 8;
  localparam int PRI_W   = 3;
  localparam int VEC_W   = 8;

  logic                     clk;
  logic                     reset;
  logic [NUM_SRC-1:0]       irq_req;
  logic [NUM_SRC-1:0]       irq_mask;
  logic [NUM_SRC*PRI_W-1:0] src_pri;
  logic [NUM_SRC*VEC_W-1:0] src_vec;
  logic [PRI_W-1:0]         cur_priority;
  logic                     int_ack;
  logic                     int_done;
  logic                     INT;
  logic [VEC_W-1:0]         INTV;
  logic [PRI_W-1:0]         Int_Priority;
  logic [NUM_SRC-1:0]       ack_src;
  logic [NUM_SRC-1:0]       pending;
  logic [3:0]               depth;
  logic                     err;

  int n_tests = 0;
  int n_fail  = 0;

  lc3_int_ctrl #(
    .NUM_SRC (NUM_SRC),
    .PRI_W   (PRI_W),
    .VEC_W   (VEC_W),
    .MAX_NEST(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_req     (irq_req),
    .irq_mask    (irq_mask),
    .src_pri     (src_pri),
    .src_vec     (src_vec),
    .cur_priority(cur_priority),
    .int_ack     (int_ack),
    .int_done    (int_done),
    .INT         (INT),
    .INTV        (INTV),
    .Int_Priority(Int_Priority),
    .ack_src     (ack_src),
    .pending     (pending),
    .depth       (depth),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [PRI_W-1:0] p, input logic [VEC_W-1:0] v);
    src_pri[i*PRI_W +: PRI_W] = p;
    src_vec[i*VEC_W +: VEC_W] = v;
  endtask

  // Asserted and released between clock edges.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    irq_req = '0;
    cur_priority = '0;
    step();
  endtask

  initial begin
    reset = 1'b0;
    irq_req = '0;
    irq_mask = '0;
    src_pri = '0;
    src_vec = '0;
    cur_priority = '0;
    int_ack = 1'b0;
    int_done = 1'b0;
    set_src(0, 3'd2, 8'h0A);
    set_src(1, 3'd4, 8'h11);
    set_src(2, 3'd7, 8'h22);
    set_src(3, 3'd5, 8'h80);
    set_src(5, 3'd7, 8'h55);
    set_src(6, 3'd6, 8'h66);

    #2;
    chk("rst_INT", 32'(INT), 32'd0);
    chk("rst_INTV", 32'(INTV), 32'h0);
    chk("rst_pri", 32'(Int_Priority), 32'd0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #1 reset = 1'b1;
    step();

    // Single request on source 3
    irq_req[3] = 1'b1;
    step();
    chk("single_pending", 32'(pending), 32'h08);
    chk("single_INT_early", 32'(INT), 32'd0);
    irq_req[3] = 1'b0;
    step();
    chk("single_INT", 32'(INT), 32'd1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("single_INTV", 32'(INTV), 32'h80);
    chk("single_pri", 32'(Int_Priority), 32'd5);
    chk("single_ack_src", 32'(ack_src), 32'h08);
    chk("single_pend_clr", 32'(pending), 32'h0);
    chk("single_depth", 32'(depth), 32'd1);
    chk("single_INT_ack", 32'(INT), 32'd0);
    step();
    chk("single_ack_pulse", 32'(ack_src), 32'h0);
    int_done = 1'b1;
    step();
    int_done = 1'b0;
    chk("single_done_depth", 32'(depth), 32'd0);
    chk("single_INTV_hold", 32'(INTV), 32'h80);

    // Priority: 6 (pri 6) beats 1 (pri 4)
    irq_req[1] = 1'b1;
    irq_req[6] = 1'b1;
    step();
    irq_req = '0;
    chk("prio_pending", 32'(pending), 32'h42);
    step();
    chk("prio_INT", 32'(INT), 32'd1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("prio_INTV", 32'(INTV), 32'h66);
    chk("prio_pri", 32'(Int_Priority), 32'd6);
    chk("prio_ack_src", 32'(ack_src), 32'h40);
    chk("prio_pending2", 32'(pending), 32'h02);
    step();
    chk("prio_INT_again", 32'(INT), 32'd1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("prio_INTV2", 32'(INTV), 32'h11);
    chk("prio_depth2", 32'(depth), 32'd2);
    int_done = 1'b1;
    step();
    step();
    int_done = 1'b0;
    chk("prio_depth0", 32'(depth), 32'd0);
    chk("prio_INTV_hold", 32'(INTV), 32'h11);
    chk("prio_err", 32'(err), 32'd0);

    // Tie at pri 7: lowest index (2) wins; 5 stays pending under PSR=7
    irq_req[2] = 1'b1;
    irq_req[5] = 1'b1;
    step();
    irq_req = '0;
    step();
    chk("tie_INT", 32'(INT), 32'd1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    cur_priority = 3'd7;
    chk("tie_INTV", 32'(INTV), 32'h22);
    chk("tie_ack_src", 32'(ack_src), 32'h04);
    step();
    step();
    chk("tie_INT_blocked", 32'(INT), 32'd0);
    chk("tie_pending5", 32'(pending), 32'h20);
    pulse_reset();

    // Mask holds source 0 pending without interrupting
    irq_mask[0] = 1'b1;
    irq_req[0] = 1'b1;
    step();
    irq_req = '0;
    step();
    step();
    chk("mask_INT", 32'(INT), 32'd0);
    chk("mask_pending", 32'(pending), 32'h01);
    irq_mask[0] = 1'b0;
    step();
    chk("unmask_INT", 32'(INT), 32'd1);

    // Nesting limit of 2
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("nest_INTV0", 32'(INTV), 32'h0A);
    chk("nest_depth1", 32'(depth), 32'd1);
    irq_req[3] = 1'b1;
    step();
    irq_req = '0;
    step();
    chk("nest_INT2", 32'(INT), 32'd1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("nest_depth2", 32'(depth), 32'd2);
    irq_req[6] = 1'b1;
    step();
    irq_req = '0;
    step();
    chk("nest_full_INT", 32'(INT), 32'd0);
    chk("nest_full_pend", 32'(pending), 32'h40);
    int_done = 1'b1;
    step();
    int_done = 1'b0;
    chk("nest_done_depth", 32'(depth), 32'd1);
    step();
    chk("nest_done_INT", 32'(INT), 32'd1);
    chk("nest_err", 32'(err), 32'd0);

    // Ack with INT low flags err, depth untouched
    int_ack = 1'b1;
    step();
    chk("err_ack_depth", 32'(depth), 32'd2);
    chk("err_ack_INT", 32'(INT), 32'd0);
    step();
    int_ack = 1'b0;
    chk("err_ack_err", 32'(err), 32'd1);
    chk("err_ack_depth2", 32'(depth), 32'd2);

    // Async reset between edges clears outputs without a clock
    #2 reset = 1'b0;
    #1;
    chk("async_err", 32'(err), 32'd0);
    chk("async_depth", 32'(depth), 32'd0);
    chk("async_INTV", 32'(INTV), 32'h0);
    chk("async_pri", 32'(Int_Priority), 32'd0);
    #2 reset = 1'b1;
    step();

    // int_done at depth 0
    int_done = 1'b1;
    step();
    int_done = 1'b0;
    chk("err_done_err", 32'(err), 32'd1);
    chk("err_done_depth", 32'(depth), 32'd0);
    pulse_reset();

    // Collision: new edge on source 3 at the ack that clears it
    irq_req[3] = 1'b1;
    step();
    irq_req = '0;
    step();
    chk("coll_INT", 32'(INT), 32'd1);
    int_ack = 1'b1;
    irq_req[3] = 1'b1;
    step();
    int_ack = 1'b0;
    irq_req = '0;
    chk("coll_pending", 32'(pending), 32'h08);
    chk("coll_ack_src", 32'(ack_src), 32'h08);
    chk("coll_depth", 32'(depth), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
